mul_share_ctrl: RTL and testbench

Round-robin controller that shares one shift-add `multiplier` instance (`size`-bit unsigned operands, `2*size`-bit product) among `NREQ` requesters. It sits between the requesting blocks and the multiplier. It arbitrates requests, latches the winner's operands, drives the multiplier's `start`/operand inputs for exactly one cycle, captures the product, and returns it with a one-hot completion pulse. One operation is in flight at a time.

---
 rtl/mul_share_ctrl.sv | 114 +++++++++++
 tb/tb_mul_share_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin front end that shares one shift-add multiplier
// among NREQ requesters. One operation in flight; grant -> issue -> capture.
module mul_share_ctrl #(
    parameter int size = 6,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*size-1:0] a_in,
    input  logic [NREQ*size-1:0] b_in,
    output logic [NREQ-1:0]      gnt,
    output logic                 mul_start,
    output logic [size-1:0]      mul_a,
    output logic [size-1:0]      mul_b,
    input  logic [2*size-1:0]    mul_product,
    output logic [NREQ-1:0]      done,
    output logic [2*size-1:0]    result,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic [NREQ-1:0]     win, win_n;      // one-hot owner of the in-flight op
    logic [NREQ-1:0]     gnt_n, done_n;
    logic                start_n;
    logic [size-1:0]     a_n, b_n;
    logic [2*size-1:0]   result_n;

    logic                found;
    logic [PW-1:0]       win_idx;
    int                  idx;

    // Rotating-priority search: first requester at or above ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    // Next-state and next-output decode; pulses default low, data holds.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        win_n    = win;
        gnt_n    = '0;
        done_n   = '0;
        start_n  = 1'b0;
        a_n      = mul_a;
        b_n      = mul_b;
        result_n = result;
        case (state)
            IDLE: begin
                if (found) begin
                    a_n     = a_in[int'(win_idx)*size +: size];
                    b_n     = b_in[int'(win_idx)*size +: size];
                    gnt_n   = NREQ'(1) << win_idx;
                    win_n   = NREQ'(1) << win_idx;
                    start_n = 1'b1;
                    ptr_n   = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // Multiplier registers its product on this edge.
                state_n = CAPTURE;
            end
            CAPTURE: begin
                result_n = mul_product;
                done_n   = win;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            gnt       <= '0;
            done      <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            win       <= win_n;
            gnt       <= gnt_n;
            done      <= done_n;
            mul_start <= start_n;
            mul_a     <= a_n;
            mul_b     <= b_n;
            result    <= result_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioral single-cycle multiplier.
module tb_mul_share_ctrl;
    localparam int size = 6;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*size-1:0] a_in, b_in;
    logic [NREQ-1:0]      gnt, done;
    logic                 mul_start, busy;
    logic [size-1:0]      mul_a, mul_b;
    logic [2*size-1:0]    mul_product, result;

    int checks = 0;
    int failures = 0;

    mul_share_ctrl #(.size(size), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .done(done), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product registered on start, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst) mul_product <= '0;
        else     mul_product <= mul_start ? 12'(mul_a) * 12'(mul_b) : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic setop(input int i, input logic [size-1:0] a, input logic [size-1:0] b);
        a_in[i*size +: size] = a;
        b_in[i*size +: size] = b;
    endtask

    // One isolated request on requester i; checks grant, issue and completion.
    task automatic single(input string tag, input int i, input logic [size-1:0] a,
                          input logic [size-1:0] b, input logic [15:0] exp);
        setop(i, a, b);
        req = 4'(1 << i);
        tick();
        chk({tag, "_gnt"}, 16'(gnt), 16'(1 << i));
        chk({tag, "_start"}, 16'(mul_start), 16'd1);
        chk({tag, "_busy0"}, 16'(busy), 16'd1);
        req = '0;
        tick();
        chk({tag, "_gnt_drop"}, 16'(gnt), 16'd0);
        chk({tag, "_start_drop"}, 16'(mul_start), 16'd0);
        chk({tag, "_busy1"}, 16'(busy), 16'd1);
        chk({tag, "_nodone"}, 16'(done), 16'd0);
        tick();
        chk({tag, "_done"}, 16'(done), 16'(1 << i));
        chk({tag, "_result"}, 16'(result), exp);
        chk({tag, "_idle"}, 16'(busy), 16'd0);
        tick();
        chk({tag, "_done_drop"}, 16'(done), 16'd0);
        chk({tag, "_hold"}, 16'(result), exp);
    endtask

    logic [3:0]  gexp;
    logic [15:0] rexp [4];

    initial begin
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        tick(); tick();
        chk("rst_gnt", 16'(gnt), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_start", 16'(mul_start), 16'd0);
        chk("rst_a", 16'(mul_a), 16'd0);
        chk("rst_b", 16'(mul_b), 16'd0);
        chk("rst_result", 16'(result), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        tick();
        chk("idle_nogrant", 16'(gnt), 16'd0);

        single("s5x7", 0, 6'd5, 6'd7, 16'd35);
        single("max", 0, 6'd63, 6'd63, 16'd3969);
        single("zero", 0, 6'd0, 6'd63, 16'd0);

        // Simultaneous: restart with ptr=0, all four held until granted.
        rst = 1'b1; tick(); rst = 1'b0;
        setop(0, 6'd3, 6'd4);   rexp[0] = 16'd12;
        setop(1, 6'd10, 6'd11); rexp[1] = 16'd110;
        setop(2, 6'd63, 6'd2);  rexp[2] = 16'd126;
        setop(3, 6'd7, 6'd9);   rexp[3] = 16'd63;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            gexp = 4'(1 << k);
            chk("rr_gnt", 16'(gnt), 16'(gexp));
            req[k] = 1'b0;
            tick();
            tick();
            chk("rr_done", 16'(done), 16'(gexp));
            chk("rr_result", 16'(result), rexp[k]);
        end

        // Wrap/fairness: ptr=0 after grant to 3; 0101 -> 0 then 2.
        req = 4'b0101;
        tick();
        chk("wrap_gnt0", 16'(gnt), 16'd1);
        req = 4'b0100;
        tick(); tick();
        chk("wrap_done0", 16'(done), 16'd1);
        chk("wrap_res0", 16'(result), 16'd12);
        req = 4'b0101;
        tick();
        chk("wrap_gnt2", 16'(gnt), 16'd4);
        tick(); tick();
        chk("wrap_done2", 16'(done), 16'd4);
        chk("wrap_res2", 16'(result), 16'd126);
        tick();
        chk("wrap_gnt0b", 16'(gnt), 16'd1);
        req = '0;
        tick(); tick();
        chk("wrap_done0b", 16'(done), 16'd1);

        // Persistent request: grant every third edge, one done per grant.
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pers_gnt", 16'(gnt), 16'd2);
            tick();
            chk("pers_gap", 16'(gnt), 16'd0);
            tick();
            chk("pers_done", 16'(done), 16'd2);
            chk("pers_res", 16'(result), 16'd110);
        end
        req = '0;
        tick();
        chk("pers_stop", 16'(gnt), 16'd0);

        // Reset in the CAPTURE cycle drops the op; pending 1000 wins after.
        setop(0, 6'd5, 6'd7);
        req = 4'b0001;
        tick();
        chk("mid_gnt", 16'(gnt), 16'd1);
        req = 4'b1000;
        tick();
        chk("mid_capture_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        tick();
        chk("mid_nodone", 16'(done), 16'd0);
        chk("mid_result", 16'(result), 16'd0);
        chk("mid_busy", 16'(busy), 16'd0);
        chk("mid_gnt_rst", 16'(gnt), 16'd0);
        chk("mid_a", 16'(mul_a), 16'd0);
        rst = 1'b0;
        tick();
        chk("post_gnt", 16'(gnt), 16'd8);
        chk("post_a", 16'(mul_a), 16'd7);
        req = '0;
        tick(); tick();
        chk("post_done", 16'(done), 16'd8);
        chk("post_result", 16'(result), 16'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
